// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO read arbiter: FSM encoding and default sizes
// used by both the arbiter and the requester FIFO instantiations.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        POP  = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } arb_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request scanning from ptr upward,
// wrapping at NREQ. Purely combinational.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [IDW:0] pos;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ))
                pos = pos - (IDW+1)'(NREQ);
            if (req[pos[IDW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter over NREQ registered-output FIFOs, with bursts of
// up to BURST words per grant and a valid/ready output stage.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int BURST = DEF_BURST,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       fifo_empty,
    input  logic [NREQ*WIDTH-1:0] fifo_data,
    output logic [NREQ-1:0]       fifo_get,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam logic [3:0] BLAST = 4'(BURST - 1);

    arb_state_t     state;
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     burst_cnt;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (~fifo_empty),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy = (state != ARB);

    // fifo_get is set on the edge entering POP so it is high for the POP cycle only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
            fifo_get  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            fifo_get <= '0;
            case (state)
                ARB: begin
                    if (en && pick_found) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        fifo_get  <= NREQ'(1) << pick_idx;
                        state     <= POP;
                    end
                end
                POP: state <= CAP;
                CAP: begin
                    out_data  <= fifo_data[grant_id*WIDTH +: WIDTH];
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Empty flag here already reflects the previous get.
                        if (burst_cnt < BLAST && !fifo_empty[grant_id] && en) begin
                            burst_cnt <= burst_cnt + 4'd1;
                            fifo_get  <= NREQ'(1) << grant_id;
                            state     <= POP;
                        end else begin
                            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                            state  <= ARB;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: behavioural FIFOs feed the DUT, expected
// words are queued at load time and a monitor checks every output handshake.
module tb_fifo_rr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset, en, out_ready, out_valid, busy;
    logic [N-1:0]   fifo_empty, fifo_get;
    logic [N*W-1:0] fifo_data;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  grant_id;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  d;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] fq[N][$];
    int           gets[N];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B), .IDW(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_get   (fifo_get),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // Registered-output FIFO model: data_out and empty update on the get edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_get[i] && fq[i].size() > 0) begin
                logic [W-1:0] w;
                w = fq[i].pop_front();
                fifo_data[i*W +: W] <= w;
                fifo_empty[i]       <= (fq[i].size() == 0);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] d);
        fq[i].push_back(d);
        fifo_empty[i] = 1'b0;
    endtask

    task automatic expect_w(input int id, input logic [W-1:0] d);
        exp_t e;
        e.id = IW'(id);
        e.d  = d;
        sb.push_back(e);
    endtask

    // what: 0 = any get pulse, 1 = out_valid
    task automatic wait_for(input int what, input string name);
        int n = 0;
        while (!(what == 0 ? (fifo_get != 0) : out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting, got none expected event", name);
        end
    endtask

    // Runs until all expected words are out and the FSM is idle; returns the
    // number of idle (ARB) cycles seen while words were still outstanding.
    task automatic drain(input string name, output int idle);
        int n = 0;
        idle = 0;
        do begin
            @(negedge clk);
            n++;
            if (!busy && sb.size() != 0) idle++;
        end while ((sb.size() != 0 || busy) && n < 1000);
        check(name, sb.size(), 0);
    endtask

    // Monitor: output handshakes against the scoreboard, get pulses for legality.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL out_word: got id %0d data %0h expected no word", grant_id, out_data);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (grant_id !== e.id || out_data !== e.d) begin
                            errors++;
                            $display("FAIL out_word: got id %0d data %0h expected id %0d data %0h",
                                     grant_id, out_data, e.id, e.d);
                        end
                    end
                end
                if (fifo_get != 0) begin
                    int idx = 0;
                    for (int i = 0; i < N; i++) if (fifo_get[i]) idx = i;
                    checks++;
                    if (!$onehot(fifo_get) || fq[idx].size() == 0) begin
                        errors++;
                        $display("FAIL get_legal: got get %b expected one-hot to non-empty fifo", fifo_get);
                    end
                    gets[idx]++;
                end
            end
        end
    end

    initial begin
        int idle, g0;
        int gsave[N];
        reset      = 1'b1;
        en         = 1'b1;
        out_ready  = 1'b1;
        fifo_empty = '1;
        fifo_data  = '0;
        for (int i = 0; i < N; i++) gets[i] = 0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_get", fifo_get, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single word from FIFO 2 with exact cycle timing.
        push(2, 16'hA5A5);
        expect_w(2, 16'hA5A5);
        wait_for(0, "single_get_wait");
        check("single_get", fifo_get, 4'b0100);
        @(negedge clk);
        check("single_cap_get", fifo_get, 0);
        check("single_cap_valid", out_valid, 0);
        @(negedge clk);
        check("single_send_valid", out_valid, 1);
        check("single_send_id", grant_id, 2);
        check("single_send_data", out_data, 16'hA5A5);
        drain("single_drain", idle);

        // rr_ptr is 3 now, so FIFO 3 must win over FIFO 0.
        push(0, 16'h1000);
        push(3, 16'h3000);
        expect_w(3, 16'h3000);
        expect_w(0, 16'h1000);
        drain("ptr_drain", idle);

        // Round robin, all four full; rr_ptr starts at 1, bursts of 4.
        for (int i = 0; i < N; i++) gsave[i] = gets[i];
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < N; i++) push(i, W'(i * 256 + k));
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < B; k++)
                    expect_w((j + 1) % N, W'(((j + 1) % N) * 256 + r * B + k));
        drain("rr_drain", idle);
        check("rr_rearb_cycles", idle, 7);
        for (int i = 0; i < N; i++) check("rr_gets", gets[i] - gsave[i], 8);

        // Early burst end: two words, no third get.
        g0 = gets[1];
        push(1, 16'hB000);
        push(1, 16'hB001);
        expect_w(1, 16'hB000);
        expect_w(1, 16'hB001);
        drain("short_drain", idle);
        check("short_gets", gets[1] - g0, 2);
        check("short_rearb", idle, 0);

        // Six words: burst of 4, one arbitration cycle, then 2 more.
        g0 = gets[1];
        for (int k = 0; k < 6; k++) begin
            push(1, W'(16'hC000 + k));
            expect_w(1, W'(16'hC000 + k));
        end
        drain("long_drain", idle);
        check("long_gets", gets[1] - g0, 6);
        check("long_rearb", idle, 1);

        // Backpressure for 10 cycles in SEND.
        out_ready = 1'b0;
        push(2, 16'hD00D);
        expect_w(2, 16'hD00D);
        wait_for(1, "bp_wait");
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 16'hD00D);
            check("bp_get", fifo_get, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain("bp_drain", idle);

        // en dropped during CAP: current word completes, then parks idle.
        push(0, 16'hE000);
        push(0, 16'hE001);
        push(0, 16'hE002);
        expect_w(0, 16'hE000);
        wait_for(0, "en_get_wait");
        @(negedge clk);
        en = 1'b0;
        wait_for(1, "en_valid_wait");
        @(negedge clk);
        check("en_delivered", sb.size(), 0);
        for (int c = 0; c < 5; c++) begin
            check("en_idle_busy", busy, 0);
            check("en_idle_get", fifo_get, 0);
            @(negedge clk);
        end
        en = 1'b1;
        expect_w(0, 16'hE001);
        expect_w(0, 16'hE002);
        drain("en_drain", idle);

        // Async reset mid-cycle while a word waits in SEND.
        out_ready = 1'b0;
        push(1, 16'hF00F);
        wait_for(1, "rst_valid_wait");
        #2 reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        push(0, 16'h0A0A);
        push(3, 16'h3A3A);
        expect_w(0, 16'h0A0A);
        expect_w(3, 16'h3A3A);
        drain("arst_drain", idle);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin read arbiter that shares one downstream consumer among NREQ upstream 8-deep FIFOs, such as per-port command or write-data queues in the DDR2 controller. It watches each FIFO's empty flag and issues single-cycle get pulses. It captures the registered FIFO data_out one cycle after each get and presents the word on a valid/ready output. A granted FIFO may hold the grant for a burst of up to BURST words, which keeps back-to-back commands from one port contiguous.

## Interface
- WIDTH, 16, data word width; matches the FIFO WIDTH.
- NREQ, 4, number of requester FIFOs (2..8).
- BURST, 4, maximum words popped per grant (1..8).
- IDW, 2, width of grant_id; must equal clog2(NREQ).

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  when 0, no new grant starts; a grant already in progress completes its current word, then the block parks in ARB.
- fifo_empty  in  NREQ  empty flags, one per requester FIFO.
- fifo_data  in  NREQ*WIDTH  flattened FIFO data_out buses; requester i occupies bits [i*WIDTH +: WIDTH].
- fifo_get  out  NREQ  one-hot get pulse to the granted FIFO.
- out_data  out  WIDTH  captured word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- grant_id  out  IDW  index of the requester that sourced out_data.
- busy  out  1  high in any state other than ARB.

## Operation
- Reset values: fifo_get=0, out_valid=0, out_data=0, grant_id=0, busy=0, state=ARB, rr_ptr=0, burst_cnt=0.
- States: ARB, POP, CAP, SEND.
- ARB
  - If en=1 and any fifo_empty[i]=0: select the first non-empty requester scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - Register the selection into grant_id, clear burst_cnt, go to POP.
  - Otherwise stay in ARB.
- POP
  - fifo_get[grant_id]=1 for exactly this cycle (registered output).
  - Go to CAP.
- CAP
  - The FIFO's registered data_out is now valid.
  - out_data <= fifo_data[grant_id], out_valid <= 1, go to SEND.
- SEND
  - Hold out_valid and out_data stable until out_ready=1.
  - On handshake: out_valid <= 0.
    - If burst_cnt < BURST-1, fifo_empty[grant_id]=0 and en=1: burst_cnt++ and go to POP.
    - Else: rr_ptr <= (grant_id+1) mod NREQ and go to ARB.
- fifo_get is only ever asserted to a FIFO whose empty flag read 0 in the preceding decision cycle. It is never asserted in ARB, CAP or SEND.
- Wrap-around: the rr_ptr increment wraps at NREQ, not at 2^IDW.
- Fairness: a requester that stays non-empty is granted within NREQ-1 intervening grants.
- The empty flag is resampled in SEND, after the FIFO has updated from the previous get. An emptied FIFO therefore ends the burst with no extra get.
- Reset asserted mid-operation (any state) immediately returns all registers to reset values. A pending out_valid word is discarded.

## Timing
- Single pop, from ARB decision edge:
  - cycle 1: POP (get high).
  - cycle 2: CAP.
  - cycle 3: SEND with out_valid=1.
- ARB-to-first-valid: 3 cycles.
- Burst throughput with out_ready held 1: one word per 3 cycles (SEND→POP→CAP→SEND).
- Re-arbitration costs 1 extra ARB cycle.
- out_ready low stalls indefinitely in SEND with no FIFO activity.
- en falling in POP or CAP does not abort; it only blocks the next POP or grant.

## Structure
- Shared package fifo_arb_pkg holds:
  - state encoding localparams (ARB=2'd0, POP=2'd1, CAP=2'd2, SEND=2'd3);
  - default WIDTH, NREQ and BURST constants shared with the FIFO instantiations.
- One combinational sub-module, rr_pick: inputs request vector and rr_ptr; outputs found flag and index. It is the rotate-priority-rotate-back encoder.
- The top level holds the FSM, burst counter, data mux and output registers.

## Test plan
- Single word: FIFO 2 holds 16'hA5A5, others empty. Expect:
  - fifo_get=4'b0100 for one cycle;
  - 3 cycles after ARB, out_valid=1, out_data=16'hA5A5, grant_id=2;
  - then ARB with rr_ptr=3.
- Round robin: all four FIFOs hold 8 words, BURST=1, out_ready=1. Expect grant_id sequence 0,1,2,3,0,… and exactly one get per word.
- Burst and early end:
  - BURST=4, FIFO 1 holds 6 words: expect 4 consecutive words on grant 1, then re-arbitration.
  - FIFO 1 holds 2 words: burst ends after 2 words with no third get.
- Backpressure: out_ready low for 10 cycles during SEND. Expect out_data stable, fifo_get all 0, and the word delivered on the first ready cycle.
- en gating: drop en during CAP of a burst. Expect that word delivered, then ARB idle with busy=0 until en returns.
- Async reset: assert reset=0 in SEND mid-clock. Expect out_valid=0 and busy=0 immediately. After release, arbitration restarts from requester 0.
